// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: M0 (CPU) and M1 (e.g. DMA) share one bus.
// Each master owns a one-entry address-phase holding register so a losing
// request is replayed later instead of being dropped.
module ahb_master_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] HADDR_M0,
  input  logic [1:0]        HTRANS_M0,
  input  logic              HWRITE_M0,
  input  logic [2:0]        HSIZE_M0,
  input  logic [2:0]        HBURST_M0,
  input  logic [3:0]        HPROT_M0,
  input  logic              HMASTLOCK_M0,
  input  logic [DATA_W-1:0] HWDATA_M0,
  output logic [DATA_W-1:0] HRDATA_M0,
  output logic              HREADY_M0,
  output logic              HRESP_M0,
  input  logic [ADDR_W-1:0] HADDR_M1,
  input  logic [1:0]        HTRANS_M1,
  input  logic              HWRITE_M1,
  input  logic [2:0]        HSIZE_M1,
  input  logic [2:0]        HBURST_M1,
  input  logic [3:0]        HPROT_M1,
  input  logic              HMASTLOCK_M1,
  input  logic [DATA_W-1:0] HWDATA_M1,
  output logic [DATA_W-1:0] HRDATA_M1,
  output logic              HREADY_M1,
  output logic              HRESP_M1,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HMASTER,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  // Address-phase control bundle for one master
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } aph_t;

  typedef enum logic [1:0] {DO_NONE, DO_M0, DO_M1} own_e;

  aph_t       w_live [2];
  aph_t       w_src  [2];
  aph_t       r_pend [2];
  logic [1:0] r_pend_vld;
  logic [1:0] w_hready_m;
  logic [1:0] w_lreq;
  logic [1:0] w_req;
  logic       w_grant;
  logic       w_drive;
  logic       w_accept;
  aph_t       w_out;
  logic       r_owner;
  logic       r_rr_last;
  logic       r_hold;
  own_e       r_downer;

  assign w_live[0] = {HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0, HBURST_M0, HPROT_M0, HMASTLOCK_M0};
  assign w_live[1] = {HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1, HBURST_M1, HPROT_M1, HMASTLOCK_M1};

  // Per-master ready, live-request detection and request source selection
  always_comb begin
    w_hready_m[0] = (r_downer == DO_M0) ? HREADY : ~r_pend_vld[0];
    w_hready_m[1] = (r_downer == DO_M1) ? HREADY : ~r_pend_vld[1];
    for (int i = 0; i < 2; i++) begin
      w_lreq[i] = w_hready_m[i] & w_live[i].trans[1];
      w_req[i]  = r_pend_vld[i] | w_lreq[i];
      w_src[i]  = r_pend_vld[i] ? r_pend[i] : w_live[i];
    end
  end

  // Grant: wait-state hold, then burst/lock continuation, then policy
  always_comb begin
    w_grant = r_owner;
    if (r_hold) begin
      w_grant = r_owner;
    end else if ((w_req[r_owner] && (w_src[r_owner].trans == TR_SEQ)) || w_src[r_owner].lock) begin
      w_grant = r_owner;
    end else if (ARB_MODE == 0) begin
      if (w_req[0])      w_grant = 1'b0;
      else if (w_req[1]) w_grant = 1'b1;
    end else begin
      if (w_req[~r_rr_last])     w_grant = ~r_rr_last;
      else if (w_req[r_rr_last]) w_grant = r_rr_last;
    end
  end

  assign w_drive  = w_req[w_grant];
  assign w_out    = w_src[w_grant];
  assign w_accept = w_drive & HREADY;

  assign HADDR     = w_out.addr;
  assign HTRANS    = w_drive ? w_out.trans : TR_IDLE;
  assign HWRITE    = w_out.write;
  assign HSIZE     = w_out.size;
  assign HBURST    = w_out.burst;
  assign HPROT     = w_out.prot;
  assign HMASTLOCK = w_out.lock;
  assign HMASTER   = w_grant;

  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;
  assign HREADY_M0 = w_hready_m[0];
  assign HREADY_M1 = w_hready_m[1];
  assign HRESP_M0  = (r_downer == DO_M0) & HRESP;
  assign HRESP_M1  = (r_downer == DO_M1) & HRESP;

  // Write data follows whoever owns the current data phase
  always_comb begin
    HWDATA = '0;
    case (r_downer)
      DO_M0:   HWDATA = HWDATA_M0;
      DO_M1:   HWDATA = HWDATA_M1;
      default: HWDATA = '0;
    endcase
  end

  // Holding registers: capture any live request the bus did not take this cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend_vld <= '0;
      r_pend[0]  <= '0;
      r_pend[1]  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_lreq[i] && !((w_grant == 1'(i)) && HREADY)) begin
          r_pend_vld[i] <= 1'b1;
          r_pend[i]     <= w_live[i];
        end else if (r_pend_vld[i] && (w_grant == 1'(i)) && HREADY) begin
          r_pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Arbitration state: address owner, round-robin history, wait hold, data owner
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_hold    <= 1'b0;
      r_downer  <= DO_NONE;
    end else begin
      r_owner <= w_grant;
      r_hold  <= w_drive & ~HREADY;
      if (w_accept) r_rr_last <= w_grant;
      if (HREADY) begin
        if (w_accept) r_downer <= w_grant ? DO_M1 : DO_M0;
        else          r_downer <= DO_NONE;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: a fixed-priority instance (a_*) and
// a round-robin instance (b_*) share the same master/slave stimulus.
module tb_ahb_master_arbiter;

  localparam logic [1:0] ID = 2'd0;
  localparam logic [1:0] NS = 2'd2;
  localparam logic [1:0] SQ = 2'd3;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR_M0 = '0, HADDR_M1 = '0;
  logic [1:0]  HTRANS_M0 = ID, HTRANS_M1 = ID;
  logic        HWRITE_M0 = 1'b0, HWRITE_M1 = 1'b0;
  logic [2:0]  HSIZE_M0 = 3'd2, HSIZE_M1 = 3'd2;
  logic [2:0]  HBURST_M0 = 3'd0, HBURST_M1 = 3'd0;
  logic [3:0]  HPROT_M0 = 4'h3, HPROT_M1 = 4'h3;
  logic        HMASTLOCK_M0 = 1'b0, HMASTLOCK_M1 = 1'b0;
  logic [31:0] HWDATA_M0 = '0, HWDATA_M1 = '0;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  logic [31:0] a_HRDATA_M0, a_HRDATA_M1, a_HADDR, a_HWDATA;
  logic        a_HREADY_M0, a_HREADY_M1, a_HRESP_M0, a_HRESP_M1;
  logic [1:0]  a_HTRANS;
  logic        a_HWRITE, a_HMASTLOCK, a_HMASTER;
  logic [2:0]  a_HSIZE, a_HBURST;
  logic [3:0]  a_HPROT;

  logic [31:0] b_HRDATA_M0, b_HRDATA_M1, b_HADDR, b_HWDATA;
  logic        b_HREADY_M0, b_HREADY_M1, b_HRESP_M0, b_HRESP_M1;
  logic [1:0]  b_HTRANS;
  logic        b_HWRITE, b_HMASTLOCK, b_HMASTER;
  logic [2:0]  b_HSIZE, b_HBURST;
  logic [3:0]  b_HPROT;

  ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0), .HSIZE_M0(HSIZE_M0),
    .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0), .HMASTLOCK_M0(HMASTLOCK_M0), .HWDATA_M0(HWDATA_M0),
    .HRDATA_M0(a_HRDATA_M0), .HREADY_M0(a_HREADY_M0), .HRESP_M0(a_HRESP_M0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1),
    .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1), .HMASTLOCK_M1(HMASTLOCK_M1), .HWDATA_M1(HWDATA_M1),
    .HRDATA_M1(a_HRDATA_M1), .HREADY_M1(a_HREADY_M1), .HRESP_M1(a_HRESP_M1),
    .HADDR(a_HADDR), .HTRANS(a_HTRANS), .HWRITE(a_HWRITE), .HSIZE(a_HSIZE), .HBURST(a_HBURST),
    .HPROT(a_HPROT), .HMASTLOCK(a_HMASTLOCK), .HWDATA(a_HWDATA), .HMASTER(a_HMASTER),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0), .HSIZE_M0(HSIZE_M0),
    .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0), .HMASTLOCK_M0(HMASTLOCK_M0), .HWDATA_M0(HWDATA_M0),
    .HRDATA_M0(b_HRDATA_M0), .HREADY_M0(b_HREADY_M0), .HRESP_M0(b_HRESP_M0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1),
    .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1), .HMASTLOCK_M1(HMASTLOCK_M1), .HWDATA_M1(HWDATA_M1),
    .HRDATA_M1(b_HRDATA_M1), .HREADY_M1(b_HREADY_M1), .HRESP_M1(b_HRESP_M1),
    .HADDR(b_HADDR), .HTRANS(b_HTRANS), .HWRITE(b_HWRITE), .HSIZE(b_HSIZE), .HBURST(b_HBURST),
    .HPROT(b_HPROT), .HMASTLOCK(b_HMASTLOCK), .HWDATA(b_HWDATA), .HMASTER(b_HMASTER),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rst;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        rdy;
    logic [31:0] rdata;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_mst;
    logic        e_rdy0;
    logic        e_rdy1;
    logic [31:0] e_rd0;
  } vec_t;

  vec_t vecs [17];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    HTRANS_M0 = ID; HADDR_M0 = '0; HWRITE_M0 = 1'b0; HWDATA_M0 = '0;
    HTRANS_M1 = ID; HADDR_M1 = '0; HWRITE_M1 = 1'b0; HWDATA_M1 = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
  endtask

  // Called just after a rising edge; returns just after a later rising edge with reset released.
  task automatic apply_reset();
    HRESETn = 1'b0;
    drive_idle();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst  t0  a0             t1  a1           rdy   rdata          e_trans e_addr         mst   rdy0  rdy1  rd0
    vecs[0]  = '{1'b1, NS, 32'h2000_0000, ID, 32'h0,    1'b1, 32'h0,        NS, 32'h2000_0000, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b1, 32'h1234_5678, ID, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1234_5678};
    vecs[2]  = '{1'b1, NS, 32'h100,       NS, 32'h200,  1'b1, 32'h0,        NS, 32'h100,       1'b0, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b1, 32'h0,        NS, 32'h200,       1'b1, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b1, 32'h0,        ID, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, NS, 32'h0,         ID, 32'h0,    1'b1, 32'h0,        NS, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, SQ, 32'h4,         NS, 32'h200,  1'b1, 32'h0,        SQ, 32'h4,         1'b0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, SQ, 32'h8,         ID, 32'h0,    1'b1, 32'h0,        SQ, 32'h8,         1'b0, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, SQ, 32'hC,         ID, 32'h0,    1'b1, 32'h0,        SQ, 32'hC,         1'b0, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b1, 32'h0,        NS, 32'h200,       1'b1, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b1, 32'h0,        ID, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0};
    vecs[11] = '{1'b1, NS, 32'h100,       ID, 32'h0,    1'b1, 32'h0,        NS, 32'h100,       1'b0, 1'b1, 1'b1, 32'h0};
    vecs[12] = '{1'b0, ID, 32'h0,         NS, 32'h5000, 1'b0, 32'h0,        NS, 32'h5000,      1'b1, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b0, 32'h0,        NS, 32'h5000,      1'b1, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b0, 32'h0,        NS, 32'h5000,      1'b1, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b1, 32'h0,        NS, 32'h5000,      1'b1, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{1'b0, ID, 32'h0,         ID, 32'h0,    1'b1, 32'h0,        ID, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0};

    // Reset values while HRESETn is held low with idle masters
    drive_idle();
    HRESETn = 1'b0;
    #12;
    chk("rst_htrans_a",  32'(a_HTRANS),    32'(ID));
    chk("rst_hmaster_a", 32'(a_HMASTER),   32'h0);
    chk("rst_hready0_a", 32'(a_HREADY_M0), 32'h1);
    chk("rst_hready1_a", 32'(a_HREADY_M1), 32'h1);
    chk("rst_hresp1_a",  32'(a_HRESP_M1),  32'h0);
    chk("rst_htrans_b",  32'(b_HTRANS),    32'(ID));
    chk("rst_hwdata_a",  a_HWDATA,         32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Fixed-priority vector table on instance a
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst) apply_reset();
      else begin
        @(posedge HCLK);
        #1;
      end
      HTRANS_M0 = vecs[i].t0; HADDR_M0 = vecs[i].a0;
      HTRANS_M1 = vecs[i].t1; HADDR_M1 = vecs[i].a1;
      HREADY = vecs[i].rdy;   HRDATA = vecs[i].rdata;
      @(negedge HCLK);
      chk($sformatf("v%0d_htrans", i),  32'(a_HTRANS),    32'(vecs[i].e_trans));
      chk($sformatf("v%0d_haddr", i),   a_HADDR,          vecs[i].e_addr);
      chk($sformatf("v%0d_hmaster", i), 32'(a_HMASTER),   32'(vecs[i].e_mst));
      chk($sformatf("v%0d_hready0", i), 32'(a_HREADY_M0), 32'(vecs[i].e_rdy0));
      chk($sformatf("v%0d_hready1", i), 32'(a_HREADY_M1), 32'(vecs[i].e_rdy1));
      chk($sformatf("v%0d_hrdata0", i), a_HRDATA_M0,      vecs[i].e_rd0);
    end

    // Round-robin alternation on instance b with both masters always requesting
    @(posedge HCLK);
    #1;
    apply_reset();
    HTRANS_M0 = NS; HADDR_M0 = 32'h1000;
    HTRANS_M1 = NS; HADDR_M1 = 32'h2000;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge HCLK);
        #1;
      end
      @(negedge HCLK);
      chk($sformatf("rr%0d_hmaster", c), 32'(b_HMASTER), 32'(c % 2));
      chk($sformatf("rr%0d_haddr", c),   b_HADDR,        (c % 2 == 0) ? 32'h1000 : 32'h2000);
    end

    // M1 write data phase alongside a stalled M0 read, then reset with pend_M0 valid
    @(posedge HCLK);
    #1;
    apply_reset();
    HTRANS_M1 = NS; HADDR_M1 = 32'h300; HWRITE_M1 = 1'b1;
    @(negedge HCLK);
    chk("wr_hmaster", 32'(a_HMASTER), 32'h1);
    chk("wr_hwrite",  32'(a_HWRITE),  32'h1);
    @(posedge HCLK);
    #1;
    HTRANS_M1 = ID; HWRITE_M1 = 1'b0; HWDATA_M1 = 32'hCAFE_F00D;
    HTRANS_M0 = NS; HADDR_M0 = 32'h400;
    HREADY = 1'b0; HRESP = 1'b1;
    @(negedge HCLK);
    chk("wr_hwdata_c1",  a_HWDATA,          32'hCAFE_F00D);
    chk("wr_hmaster_c1", 32'(a_HMASTER),    32'h0);
    chk("wr_haddr_c1",   a_HADDR,           32'h400);
    chk("wr_hresp1_c1",  32'(a_HRESP_M1),   32'h1);
    chk("wr_hresp0_c1",  32'(a_HRESP_M0),   32'h0);
    chk("wr_hready1_c1", 32'(a_HREADY_M1),  32'h0);
    @(posedge HCLK);
    #1;
    HTRANS_M0 = ID; HADDR_M0 = '0;
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    chk("wr_hwdata_c2",  a_HWDATA,          32'hCAFE_F00D);
    chk("pend_haddr_c2", a_HADDR,           32'h400);
    chk("pend_htrans_c2", 32'(a_HTRANS),    32'(NS));
    chk("pend_hready0_c2", 32'(a_HREADY_M0), 32'h0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_htrans",  32'(a_HTRANS),    32'(ID));
    chk("mid_rst_hready0", 32'(a_HREADY_M0), 32'h1);
    chk("mid_rst_hready1", 32'(a_HREADY_M1), 32'h1);
    chk("mid_rst_hwdata",  a_HWDATA,         32'h0);
    chk("mid_rst_hmaster", 32'(a_HMASTER),   32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      chk($sformatf("post_rst%0d_htrans", c),  32'(a_HTRANS),    32'(ID));
      chk($sformatf("post_rst%0d_hready0", c), 32'(a_HREADY_M0), 32'h1);
      @(posedge HCLK);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
Two-master AHB-Lite arbiter that shares the single system bus between the Cortex-M0 (M0) and a second bus master such as a DMA engine (M1). It sits between the masters and the existing address decoder, slave multiplexer and slaves. Each master has a one-entry address-phase holding register, so a master that loses arbitration is wait-stated rather than dropped. The slave side looks like a single AHB-Lite master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ARB_MODE, 0, 0 = fixed priority (M0 wins); 1 = round-robin

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HADDR_M0/HADDR_M1  in  ADDR_W  master address
HTRANS_M0/HTRANS_M1  in  2  master transfer type
HWRITE_M0/HWRITE_M1  in  1  master write
HSIZE_M0/HSIZE_M1  in  3  master size
HBURST_M0/HBURST_M1  in  3  master burst
HPROT_M0/HPROT_M1  in  4  master protection
HMASTLOCK_M0/HMASTLOCK_M1  in  1  master lock
HWDATA_M0/HWDATA_M1  in  DATA_W  master write data
HRDATA_M0/HRDATA_M1  out  DATA_W  read data to master
HREADY_M0/HREADY_M1  out  1  ready to master
HRESP_M0/HRESP_M1  out  1  response to master
HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA  out  (as above)  slave-side bus
HMASTER  out  1  current address-phase owner (0 = M0, 1 = M1)
HRDATA  in  DATA_W  slave-side read data
HREADY  in  1  slave-side ready (from slave mux)
HRESP  in  1  slave-side response

Behaviour:
- Clocking: single clock HCLK. Reset HRESETn is asynchronous and active-low.
- Reset values:
  - pend_M0 and pend_M1 cleared; data_owner = NONE; rr_last = M1 (so M0 wins the first round-robin tie); hold = 0.
  - HTRANS = IDLE; HMASTER = 0; HREADY_M0 = HREADY_M1 = 1; HRESP_Mx = 0.
  - Other slave-side outputs follow the M0 mux path.
- Live request (Lx): HREADY_Mx = 1 and HTRANS_Mx[1] = 1 (NONSEQ or SEQ).
- Request (Rx): pend_Mx valid, or Lx. The source is the pending register when valid, otherwise the live inputs.
- Grant is combinational, in this priority order:
  1. If hold = 1, keep the previous owner.
  2. If the previous owner's request is SEQ or it has HMASTLOCK set, keep the owner.
  3. Otherwise ARB_MODE 0 picks M0 first; ARB_MODE 1 picks the master other than rr_last.
  4. If there is no request, keep the previous owner and drive HTRANS = IDLE.
- Slave outputs: muxed from the granted source. HMASTER = grant.
- Capture: on any Lx that is not (granted AND HREADY = 1), load pend_Mx with {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK}.
- Clear: pend_Mx clears when it is granted AND HREADY = 1.
- hold register: set to 1 when a NONSEQ/SEQ is driven and HREADY = 0; cleared otherwise.
  - The address bus stays stable across slave wait states.
  - A live request driven into a wait state is captured, so the next cycle shows the identical value from pend_Mx.
- rr_last: updated to grant on each accepted transfer, i.e. HTRANS[1] & HREADY.
- data_owner: updated when HREADY = 1 to grant if a transfer was accepted, else NONE.
- HWDATA: muxed by data_owner. When data_owner = NONE, output 0.
- HRDATA_Mx: driven by HRDATA for both masters (broadcast).
- HRESP_Mx: HRESP when data_owner = Mx, else 0.
- HREADY_Mx:
  - HREADY when data_owner = Mx;
  - else 0 when pend_Mx is valid;
  - else 1.
- Latency:
  - An uncontested live request is forwarded in the same cycle (zero added latency).
  - A losing request is forwarded no earlier than the next cycle. Its master sees HREADY_Mx = 0 until that transfer's data phase completes.
- Simultaneous capture and clear of the same pend_Mx cannot occur. A master cannot present Lx while pend_Mx is valid, because HREADY_Mx = 0.
- IDLE and BUSY are never captured.
- Reset asserted mid-transfer: pending and in-flight state are dropped immediately and outputs take their reset values.

Test Plan:
1. M0 NONSEQ read of 0x2000_0000, M1 idle, HREADY = 1 → HADDR = 0x2000_0000 and HMASTER = 0 in the same cycle; HRDATA 0x12345678 reaches HRDATA_M0 with HREADY_M0 = 1 on the next cycle.
2. ARB_MODE = 0; M0 NONSEQ to 0x100 and M1 NONSEQ to 0x200 in cycle N → 0x100 on the bus at N; 0x200 captured and on the bus at N+1 with HMASTER = 1; HREADY_M1 = 0 at N+1 and 1 at N+2.
3. ARB_MODE = 1; both masters issue back-to-back NONSEQ for 6 cycles → HMASTER sequence is 0,1,0,1,0,1.
4. M0 INCR4 burst (NONSEQ + 3×SEQ) at 0x0; M1 requests during beat 2 → all 4 M0 beats are contiguous; M1's address follows immediately after, with HREADY_M1 = 0 throughout.
5. Slave holds HREADY = 0 for 3 cycles while M1 issues NONSEQ 0x5000 → HADDR/HTRANS stay constant over the wait cycles; M1's transfer is issued on the first cycle after HREADY returns high.
6. M1 write of 0xCAFEF00D concurrent with an M0 read; then HRESETn is pulsed low while pend_M0 is valid → HWDATA = 0xCAFEF00D during M1's data phase; after reset, HTRANS = IDLE, HREADY_Mx = 1, and the pending transfer is never issued.
